// File: rtl/qpp_pkg.sv
// Shared definitions for the LTE QPP stream interleaver: block-size select
// encoding and the per-size constants of the permutation
// pi(i) = (f1*i + f2*i^2) mod K.
package qpp_pkg;

  localparam int QPP_KMAX   = 6144;
  localparam int QPP_IDX_W  = 13;
  localparam int QPP_DATA_W = 8;

  typedef enum logic [1:0] {
    KSEL_40   = 2'd0,
    KSEL_512  = 2'd1,
    KSEL_1056 = 2'd2,
    KSEL_6144 = 2'd3
  } qpp_ksel_e;

  typedef logic [QPP_IDX_W-1:0] qpp_idx_t;

  // Block size K in bits
  function automatic qpp_idx_t qpp_k(input logic [1:0] ks);
    case (ks)
      KSEL_40:   return qpp_idx_t'(40);
      KSEL_512:  return qpp_idx_t'(512);
      KSEL_1056: return qpp_idx_t'(1056);
      default:   return qpp_idx_t'(6144);
    endcase
  endfunction

  // Linear coefficient f1
  function automatic qpp_idx_t qpp_f1(input logic [1:0] ks);
    case (ks)
      KSEL_40:   return qpp_idx_t'(3);
      KSEL_512:  return qpp_idx_t'(31);
      KSEL_1056: return qpp_idx_t'(17);
      default:   return qpp_idx_t'(263);
    endcase
  endfunction

  // Quadratic coefficient f2
  function automatic qpp_idx_t qpp_f2(input logic [1:0] ks);
    case (ks)
      KSEL_40:   return qpp_idx_t'(10);
      KSEL_512:  return qpp_idx_t'(64);
      KSEL_1056: return qpp_idx_t'(66);
      default:   return qpp_idx_t'(480);
    endcase
  endfunction

  // Second difference of pi: (2*f2) mod K, the constant step applied to g
  function automatic qpp_idx_t qpp_f2x2(input logic [1:0] ks);
    case (ks)
      KSEL_40:   return qpp_idx_t'(20);
      KSEL_512:  return qpp_idx_t'(128);
      KSEL_1056: return qpp_idx_t'(132);
      default:   return qpp_idx_t'(960);
    endcase
  endfunction

  // First difference of pi at i=0: (f1 + f2) mod K
  function automatic qpp_idx_t qpp_g0(input logic [1:0] ks);
    case (ks)
      KSEL_40:   return qpp_idx_t'(13);
      KSEL_512:  return qpp_idx_t'(95);
      KSEL_1056: return qpp_idx_t'(83);
      default:   return qpp_idx_t'(743);
    endcase
  endfunction

endpackage

// File: rtl/qpp_addr_gen.sv
// Incremental QPP address generator. Tracks the natural index i and the
// interleaved index pi(i) using the first difference g:
//   pi(i+1) = pi(i) + g(i),  g(i+1) = g(i) + 2*f2   (all mod K)
// Operands are always below K, so each mod is one conditional subtract.
module qpp_addr_gen
  import qpp_pkg::*;
#(
  parameter int IDX_W = QPP_IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic [1:0]       init_ksel,
  input  logic             adv,
  output logic [IDX_W-1:0] idx,
  output logic [IDX_W-1:0] pi,
  output logic [IDX_W-1:0] idx_nxt,
  output logic [IDX_W-1:0] pi_nxt,
  output logic             done,
  output logic [1:0]       ksel
);

  logic [IDX_W-1:0] k;
  logic [IDX_W-1:0] f2x2;
  logic [IDX_W-1:0] g_q;
  logic [IDX_W-1:0] g_nxt;
  logic [IDX_W:0]   pi_sum;
  logic [IDX_W:0]   g_sum;

  assign k    = IDX_W'(qpp_k(ksel));
  assign f2x2 = IDX_W'(qpp_f2x2(ksel));

  assign idx_nxt = idx + IDX_W'(1);
  assign pi_sum  = {1'b0, pi} + {1'b0, g_q};
  assign g_sum   = {1'b0, g_q} + {1'b0, f2x2};
  assign pi_nxt  = (pi_sum >= {1'b0, k}) ? IDX_W'(pi_sum - {1'b0, k}) : pi_sum[IDX_W-1:0];
  assign g_nxt   = (g_sum >= {1'b0, k}) ? IDX_W'(g_sum - {1'b0, k}) : g_sum[IDX_W-1:0];
  assign done    = (idx == k - IDX_W'(1));

  // Index state: load block start on init, step the recurrence on adv
  always_ff @(posedge clk) begin
    if (reset) begin
      idx  <= '0;
      pi   <= '0;
      g_q  <= '0;
      ksel <= '0;
    end else if (init) begin
      idx  <= '0;
      pi   <= '0;
      g_q  <= IDX_W'(qpp_g0(init_ksel));
      ksel <= init_ksel;
    end else if (adv) begin
      idx  <= idx_nxt;
      pi   <= pi_nxt;
      g_q  <= g_nxt;
    end
  end

endmodule

// File: rtl/qpp_stream_interleaver.sv
// Streaming LTE turbo QPP interleaver. Bytes are written into one of two
// ping-pong banks; a full bank is drained bit-serially as the pair
// (c(i), c(pi(i))) at one pair per cycle while the other bank fills.
module qpp_stream_interleaver
  import qpp_pkg::*;
#(
  parameter int KMAX   = QPP_KMAX,
  parameter int DATA_W = QPP_DATA_W,
  parameter int IDX_W  = QPP_IDX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        k_sel,
  input  logic              in_start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_ci,
  output logic              out_cpii,
  output logic              out_first,
  output logic              out_last,
  output logic [1:0]        out_k_sel,
  output logic              err_abort
);

  localparam int SHW   = $clog2(DATA_W);
  localparam int DEPTH = KMAX / DATA_W;
  localparam int WA_W  = $clog2(DEPTH);

  typedef enum logic {W_IDLE, W_FILL} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_PRIME, R_DRAIN} rd_state_e;

  // Bank storage and bank bookkeeping
  logic [DATA_W-1:0] mem [2][DEPTH];
  logic [1:0]        bank_full;
  logic [1:0]        bank_ksel [2];
  logic              wptr;
  logic              rptr;

  // Write side
  wr_state_e        w_st, w_nxt;
  logic [WA_W-1:0]  wcnt, wcnt_nxt, wr_addr, word_last;
  logic             in_acc, wr_en, latch_ksel, fill_done, abort;
  logic [IDX_W-1:0] fill_k;

  // Read side
  rd_state_e        r_st, r_nxt;
  logic             ag_init, ag_adv, rd_load, drain_done;
  logic [1:0]       ag_init_ksel;
  logic [IDX_W-1:0] ag_idx, ag_pi, ag_idx_nxt, ag_pi_nxt;
  logic             ag_done;
  logic [IDX_W-1:0] rd_i_addr, rd_pi_addr;
  logic [DATA_W-1:0] word_i, word_pi;
  logic             ci_p1, cpii_p1, vld_p1;

  // ---------------------------------------------------------------- write
  assign in_ready  = (w_st == W_FILL) || !(&bank_full);
  assign in_acc    = in_valid && in_ready;
  assign fill_k    = IDX_W'(qpp_k(bank_ksel[wptr]));
  assign word_last = WA_W'(fill_k >> SHW) - WA_W'(1);

  // Write FSM next state: word placement, fill completion and restart detection
  always_comb begin
    w_nxt      = w_st;
    wcnt_nxt   = wcnt;
    wr_en      = 1'b0;
    wr_addr    = wcnt;
    latch_ksel = 1'b0;
    fill_done  = 1'b0;
    abort      = 1'b0;
    case (w_st)
      W_IDLE: begin
        if (in_acc && in_start) begin
          latch_ksel = 1'b1;
          wr_en      = 1'b1;
          wr_addr    = '0;
          wcnt_nxt   = WA_W'(1);
          w_nxt      = W_FILL;
        end
      end
      W_FILL: begin
        if (in_acc) begin
          wr_en = 1'b1;
          if (in_start) begin
            abort      = 1'b1;
            latch_ksel = 1'b1;
            wr_addr    = '0;
            wcnt_nxt   = WA_W'(1);
          end else if (wcnt == word_last) begin
            fill_done = 1'b1;
            wcnt_nxt  = '0;
            w_nxt     = W_IDLE;
          end else begin
            wcnt_nxt = wcnt + WA_W'(1);
          end
        end
      end
      default: w_nxt = W_IDLE;
    endcase
  end

  // Write FSM state, word counter, block size latch and abort pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      w_st         <= W_IDLE;
      wcnt         <= '0;
      wptr         <= 1'b0;
      bank_ksel[0] <= '0;
      bank_ksel[1] <= '0;
      err_abort    <= 1'b0;
    end else begin
      w_st      <= w_nxt;
      wcnt      <= wcnt_nxt;
      err_abort <= abort;
      if (latch_ksel) bank_ksel[wptr] <= k_sel;
      if (fill_done)  wptr <= ~wptr;
    end
  end

  // Bank flags: fill and drain always target different banks, so both apply
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_full <= '0;
    end else begin
      if (fill_done)  bank_full[wptr] <= 1'b1;
      if (drain_done) bank_full[rptr] <= 1'b0;
    end
  end

  // Bank write port; MSB of each word lands at the lowest bit index
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr][wr_addr] <= in_data;
  end

  // ----------------------------------------------------------------- read
  // Read FSM next state: start, prime and drain blocks; chain to the other bank
  always_comb begin
    r_nxt        = r_st;
    ag_init      = 1'b0;
    ag_init_ksel = bank_ksel[rptr];
    ag_adv       = 1'b0;
    rd_load      = 1'b0;
    drain_done   = 1'b0;
    case (r_st)
      R_IDLE: begin
        if (bank_full[rptr]) begin
          ag_init = 1'b1;
          r_nxt   = R_PRIME;
        end
      end
      R_PRIME: begin
        rd_load = 1'b1;
        r_nxt   = R_DRAIN;
      end
      R_DRAIN: begin
        if (out_ready) begin
          if (ag_done) begin
            drain_done = 1'b1;
            if (bank_full[~rptr]) begin
              ag_init      = 1'b1;
              ag_init_ksel = bank_ksel[~rptr];
              r_nxt        = R_PRIME;
            end else begin
              r_nxt = R_IDLE;
            end
          end else begin
            ag_adv  = 1'b1;
            rd_load = 1'b1;
          end
        end
      end
      default: r_nxt = R_IDLE;
    endcase
  end

  // Read FSM state and read-bank pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_st <= R_IDLE;
      rptr <= 1'b0;
    end else begin
      r_st <= r_nxt;
      if (drain_done) rptr <= ~rptr;
    end
  end

  qpp_addr_gen #(
    .IDX_W (IDX_W)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .init      (ag_init),
    .init_ksel (ag_init_ksel),
    .adv       (ag_adv),
    .idx       (ag_idx),
    .pi        (ag_pi),
    .idx_nxt   (ag_idx_nxt),
    .pi_nxt    (ag_pi_nxt),
    .done      (ag_done),
    .ksel      (out_k_sel)
  );

  // Stage p0: read addresses look ahead when a pair is consumed
  assign rd_i_addr  = ag_adv ? ag_idx_nxt : ag_idx;
  assign rd_pi_addr = ag_adv ? ag_pi_nxt  : ag_pi;
  assign word_i     = mem[rptr][rd_i_addr[SHW +: WA_W]];
  assign word_pi    = mem[rptr][rd_pi_addr[SHW +: WA_W]];

  // Registered bit reads; held while downstream stalls
  always_ff @(posedge clk) begin
    if (rd_load) begin
      ci_p1   <= word_i[~rd_i_addr[SHW-1:0]];
      cpii_p1 <= word_pi[~rd_pi_addr[SHW-1:0]];
    end
  end

  // Stage p1: output pair
  assign vld_p1    = (r_st == R_DRAIN);
  assign out_valid = vld_p1;
  assign out_ci    = vld_p1 & ci_p1;
  assign out_cpii  = vld_p1 & cpii_p1;
  assign out_first = vld_p1 && (ag_idx == '0);
  assign out_last  = vld_p1 && ag_done;

endmodule

// File: tb/tb_qpp_stream_interleaver.sv
// Scoreboard bench for qpp_stream_interleaver: the stimulus process pushes
// the expected (c(i), c(pi(i))) sequence of every completed block; a monitor
// pops and compares each consumed pair and watches stall stability.
module tb_qpp_stream_interleaver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] k_sel = 2'd0;
  logic       in_start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_ci, out_cpii, out_first, out_last;
  logic [1:0] out_k_sel;
  logic       err_abort;

  always #5 clk = ~clk;

  qpp_stream_interleaver dut (
    .clk       (clk),
    .reset     (reset),
    .k_sel     (k_sel),
    .in_start  (in_start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ci    (out_ci),
    .out_cpii  (out_cpii),
    .out_first (out_first),
    .out_last  (out_last),
    .out_k_sel (out_k_sel),
    .err_abort (err_abort)
  );

  typedef struct packed {
    logic       ci;
    logic       cpii;
    logic       first;
    logic       last;
    logic [1:0] ks;
  } pair_t;

  pair_t exp_q[$];
  bit    blk_bits [6144];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    last_cyc = 0;
  int    abort_cnt = 0;
  int    stall_cnt = 0;
  int    bubble_seen = 0;
  bit    have_last = 1'b0;
  bit    chk_bubble = 1'b0;
  bit    rnd_ready = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, req, $time);
    end
  endtask

  // Reference: the LTE QPP table and closed-form permutation
  function automatic int k_of(input int ks);
    case (ks)
      0:       return 40;
      1:       return 512;
      2:       return 1056;
      default: return 6144;
    endcase
  endfunction

  function automatic int pi_of(input int ks, input int i);
    longint f1, f2, k, li;
    case (ks)
      0:       begin f1 = 3;   f2 = 10;  end
      1:       begin f1 = 31;  f2 = 64;  end
      2:       begin f1 = 17;  f2 = 66;  end
      default: begin f1 = 263; f2 = 480; end
    endcase
    k  = longint'(k_of(ks));
    li = longint'(i);
    return int'((f1 * li + f2 * li * li) % k);
  endfunction

  task automatic clear_bits();
    for (int i = 0; i < 6144; i++) blk_bits[i] = 1'b0;
  endtask

  task automatic rand_bits(input int k);
    clear_bits();
    for (int i = 0; i < k; i++) blk_bits[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic push_expected(input int ks);
    int    k;
    pair_t e;
    k = k_of(ks);
    for (int i = 0; i < k; i++) begin
      e.ci    = blk_bits[i];
      e.cpii  = blk_bits[pi_of(ks, i)];
      e.first = (i == 0);
      e.last  = (i == k - 1);
      e.ks    = 2'(ks);
      exp_q.push_back(e);
    end
  endtask

  // Present one word and hold it until accepted (bounded)
  task automatic send_word(input logic [7:0] d, input logic st);
    int t;
    t = 0;
    in_data  = d;
    in_start = st;
    in_valid = 1'b1;
    while (!in_ready && t < 20000) begin
      @(posedge clk); #1;
      t++;
      stall_cnt++;
    end
    if (t >= 20000) chk("in_ready_timeout", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_start = 1'b0;
  endtask

  // Send blk_bits as a block; nwords < 0 sends the whole block and expects it
  task automatic send_block(input int ks, input int nwords);
    int         nw;
    logic [7:0] d;
    nw = (nwords < 0) ? k_of(ks) / 8 : nwords;
    for (int n = 0; n < nw; n++) begin
      for (int j = 0; j < 8; j++) d[7-j] = blk_bits[8*n + j];
      k_sel = 2'(ks);
      send_word(d, n == 0);
    end
    if (nwords < 0) push_expected(ks);
  endtask

  task automatic wait_drain(input string nm);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 40000) begin
      @(posedge clk); #1;
      t++;
    end
    chk({nm, "_left"}, 64'(exp_q.size()), 64'(0));
  endtask

  // Downstream ready: always on, or random per cycle
  initial begin : ready_drv
    forever begin
      @(posedge clk); #1;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compare consumed pairs, check holds during stalls and bubbles
  initial begin : monitor
    pair_t got;
    pair_t held;
    pair_t e;
    bit    hold_v;
    hold_v = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        hold_v = 1'b0;
      end else begin
        if (err_abort) abort_cnt++;
        got = '{out_ci, out_cpii, out_first, out_last, out_k_sel};
        if (hold_v) begin
          chk("hold_valid", 64'(out_valid), 64'(1));
          chk("hold_pair", 64'(got), 64'(held));
        end
        hold_v = 1'b0;
        if (out_valid) begin
          if (!out_ready) begin
            hold_v = 1'b1;
            held   = got;
          end else begin
            if (exp_q.size() == 0) begin
              chk("spurious_out", 64'(out_valid), 64'(0));
            end else begin
              e = exp_q.pop_front();
              chk("pair", 64'(got), 64'(e));
            end
            if (got.first && chk_bubble && have_last) begin
              chk("bubble_gap", 64'(cyc - last_cyc), 64'(2));
              bubble_seen++;
            end
            if (got.last) begin
              last_cyc  = cyc;
              have_last = 1'b1;
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin : stim
    int ab0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  64'(in_ready),  64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_ci",    64'(out_ci),    64'(0));
    chk("rst_out_cpii",  64'(out_cpii),  64'(0));
    chk("rst_out_first", 64'(out_first), 64'(0));
    chk("rst_out_last",  64'(out_last),  64'(0));
    chk("rst_out_k_sel", 64'(out_k_sel), 64'(0));
    chk("rst_err_abort", 64'(err_abort), 64'(0));
    reset = 1'b0;

    // Words without in_start while idle are dropped silently
    send_word(8'hff, 1'b0);
    send_word(8'h5a, 1'b0);
    send_word(8'h81, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    chk("drop_no_output", 64'(out_valid), 64'(0));

    // K=40, only c(0)=1
    clear_bits();
    blk_bits[0] = 1'b1;
    send_block(0, -1);
    wait_drain("k40_bit0");

    // K=40, single 1 at bit 13: interleaved stream high only at i=1
    clear_bits();
    blk_bits[13] = 1'b1;
    send_block(0, -1);
    wait_drain("k40_bit13");

    // K=40, single 1 at random positions, then random data
    for (int r = 0; r < 3; r++) begin
      clear_bits();
      blk_bits[$urandom_range(0, 39)] = 1'b1;
      send_block(0, -1);
    end
    rand_bits(40);
    send_block(0, -1);
    wait_drain("k40_rand");

    // Back-to-back large blocks with one-cycle bubbles; filling never stalls
    have_last  = 1'b0;
    chk_bubble = 1'b1;
    bubble_seen = 0;
    rand_bits(6144);
    send_block(3, -1);
    stall_cnt = 0;
    rand_bits(1056);
    send_block(2, -1);
    chk("fill_during_drain_stalls", 64'(stall_cnt), 64'(0));
    rand_bits(6144);
    send_block(3, -1);
    wait_drain("b2b");
    chk_bubble = 1'b0;
    chk("bubble_count", 64'(bubble_seen), 64'(2));

    // Random downstream back-pressure with K=512
    rnd_ready = 1'b1;
    rand_bits(512);
    send_block(1, -1);
    rand_bits(512);
    send_block(1, -1);
    wait_drain("k512_bp");
    rnd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Restart after 10 of 132 words: one abort pulse, only the restart emitted
    ab0 = abort_cnt;
    rand_bits(1056);
    send_block(2, 10);
    rand_bits(1056);
    send_block(2, -1);
    wait_drain("abort");
    chk("abort_pulses", 64'(abort_cnt - ab0), 64'(1));

    // Reset in the middle of a K=6144 drain
    rand_bits(6144);
    send_block(3, -1);
    repeat (300) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_in_ready",  64'(in_ready),  64'(1));
    reset = 1'b0;
    rand_bits(40);
    send_block(0, -1);
    wait_drain("after_reset");

    chk("abort_total", 64'(abort_cnt), 64'(1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
